// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and helpers for the HUB75 BCM scheduler.
//   state_e    - scheduler FSM states
//   R/G/B_LSB  - position of each colour field in a pixel word, counted in
//                units of the per-channel width (BITS)
//   plane_bit  - pulls one bit-plane bit of one colour field out of a word
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_UNLATCH,
        ST_DISPLAY
    } state_e;

    // Pixel word is {r, g, b}, each field BITS wide, b in the low bits.
    localparam int R_LSB = 2;
    localparam int G_LSB = 1;
    localparam int B_LSB = 0;

    // Widest pixel word the helper accepts (16-bit colour depth).
    localparam int PIX_MAX_W = 48;

    // Returns bit 'plane' of colour field 'field' in a word whose fields
    // are 'bits' wide.
    function automatic logic plane_bit(input logic [PIX_MAX_W-1:0] word,
                                       input int bits,
                                       input int field,
                                       input int plane);
        logic [PIX_MAX_W-1:0] shifted;
        shifted = word >> (field * bits + plane);
        return shifted[0];
    endfunction

endpackage

// File: rtl/bcm_timer.sv
// bcm_timer: loadable down-counter that times one BCM display period.
//   i_clk, i_rst_n : clock and synchronous active-low reset
//   i_load         : load i_load_val on this edge
//   i_load_val     : period length in cycles (>= 1)
//   o_done         : high during the final cycle of the period
// After a load of N, o_done is high in the N-th cycle following the load
// edge, so a consumer that stays busy until o_done is busy exactly N cycles.
module bcm_timer #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_done
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == CW'(1));

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: frame sequencer for a 2-lane HUB75 panel using
// binary-code modulation.
//   i_clk, i_rst_n, i_enable      : clock, sync active-low reset, run request
//   o_rd_row/o_rd_col/o_rd_en     : framebuffer read; data returns 1 cycle later
//   i_pix_top/i_pix_bot           : {r,g,b} pixel words for top/bottom half
//   o_data_r/g/b                  : {bottom bit, top bit} per colour
//   o_clk_enable                  : panel shift clock gate
//   o_latch/o_blank/o_row_addr    : panel latch, blank (1 = off), row address
//   o_busy/o_frame_done           : not idle / one-cycle end-of-frame pulse
// Per (row, plane): SHIFT (COLS+1) -> BLANK -> LATCH -> UNLATCH ->
// DISPLAY (BASE_TICKS<<plane). Planes advance fastest, then rows.
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int ROWS       = 16,
    parameter int BITS       = 4,
    parameter int BASE_TICKS = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    output logic [$clog2(ROWS)-1:0] o_rd_row,
    output logic [$clog2(COLS)-1:0] o_rd_col,
    output logic                    o_rd_en,
    input  logic [3*BITS-1:0]       i_pix_top,
    input  logic [3*BITS-1:0]       i_pix_bot,
    output logic [1:0]              o_data_r,
    output logic [1:0]              o_data_g,
    output logic [1:0]              o_data_b,
    output logic                    o_clk_enable,
    output logic                    o_latch,
    output logic                    o_blank,
    output logic [$clog2(ROWS)-1:0] o_row_addr,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam int CCW = $clog2(COLS + 1);
    localparam int PW  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int CW  = $clog2(BASE_TICKS) + BITS;

    localparam logic [RW-1:0]  LAST_ROW    = RW'(ROWS - 1);
    localparam logic [PW-1:0]  LAST_PLANE  = PW'(BITS - 1);
    localparam logic [CCW-1:0] COL_END     = CCW'(COLS);
    localparam logic [CCW-1:0] COL_LAST_RD = CCW'(COLS - 1);

    state_e          r_state;
    logic [RW-1:0]   r_row;
    logic [PW-1:0]   r_plane;
    logic [CCW-1:0]  r_col;      // SHIFT cycle index 0..COLS
    logic [CLW-1:0]  r_rd_col;
    logic            r_rd_en;
    logic            r_clk_en;
    logic            r_latch;
    logic            r_blank;
    logic [RW-1:0]   r_row_addr;
    logic            r_frame_done;
    logic [1:0]      r_hold_r;
    logic [1:0]      r_hold_g;
    logic [1:0]      r_hold_b;

    logic            w_tmr_load;
    logic            w_tmr_done;
    logic [CW-1:0]   w_tmr_val;
    logic [1:0]      w_live_r;
    logic [1:0]      w_live_g;
    logic [1:0]      w_live_b;

    // Display timer is loaded on the UNLATCH->DISPLAY edge.
    assign w_tmr_load = (r_state == ST_UNLATCH);
    assign w_tmr_val  = CW'(BASE_TICKS) << r_plane;

    bcm_timer #(.CW(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Selected plane bits of the word the framebuffer is returning now.
    assign w_live_r = {plane_bit(PIX_MAX_W'(i_pix_bot), BITS, R_LSB, int'(r_plane)),
                       plane_bit(PIX_MAX_W'(i_pix_top), BITS, R_LSB, int'(r_plane))};
    assign w_live_g = {plane_bit(PIX_MAX_W'(i_pix_bot), BITS, G_LSB, int'(r_plane)),
                       plane_bit(PIX_MAX_W'(i_pix_top), BITS, G_LSB, int'(r_plane))};
    assign w_live_b = {plane_bit(PIX_MAX_W'(i_pix_bot), BITS, B_LSB, int'(r_plane)),
                       plane_bit(PIX_MAX_W'(i_pix_top), BITS, B_LSB, int'(r_plane))};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_plane      <= '0;
            r_col        <= '0;
            r_rd_col     <= '0;
            r_rd_en      <= 1'b0;
            r_clk_en     <= 1'b0;
            r_latch      <= 1'b0;
            r_blank      <= 1'b1;
            r_row_addr   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_blank  <= 1'b1;
                    r_latch  <= 1'b0;
                    r_clk_en <= 1'b0;
                    r_rd_en  <= 1'b0;
                    if (i_enable) begin
                        r_state  <= ST_SHIFT;
                        r_row    <= '0;
                        r_plane  <= '0;
                        r_col    <= '0;
                        r_rd_col <= '0;
                        r_rd_en  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Reads run on cycles 0..COLS-1, the shift clock one
                    // cycle behind on 1..COLS.
                    if (r_col == COL_END) begin
                        r_state  <= ST_BLANK;
                        r_clk_en <= 1'b0;
                        r_rd_en  <= 1'b0;
                    end else begin
                        r_col    <= r_col + 1'b1;
                        r_clk_en <= 1'b1;
                        r_rd_en  <= (r_col != COL_LAST_RD);
                        r_rd_col <= CLW'(r_col + 1'b1);
                    end
                end
                ST_BLANK: begin
                    r_state    <= ST_LATCH;
                    r_latch    <= 1'b1;
                    r_row_addr <= r_row;
                end
                ST_LATCH: begin
                    r_state <= ST_UNLATCH;
                    r_latch <= 1'b0;
                end
                ST_UNLATCH: begin
                    r_state <= ST_DISPLAY;
                    r_blank <= 1'b0;
                end
                ST_DISPLAY: begin
                    if (w_tmr_done) begin
                        r_blank  <= 1'b1;
                        r_col    <= '0;
                        r_rd_col <= '0;
                        r_state  <= ST_SHIFT;
                        r_rd_en  <= 1'b1;
                        if (r_plane != LAST_PLANE) begin
                            r_plane <= r_plane + 1'b1;
                        end else begin
                            r_plane <= '0;
                            if (r_row != LAST_ROW) begin
                                r_row <= r_row + 1'b1;
                            end else begin
                                // Frame end: the only mid-run point where
                                // i_enable is honoured.
                                r_row        <= '0;
                                r_frame_done <= 1'b1;
                                if (!i_enable) begin
                                    r_state <= ST_IDLE;
                                    r_rd_en <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_blank <= 1'b1;
                end
            endcase
        end
    end

    // The fetched word is present in the same cycle the shift clock is
    // gated on, so the bit passes straight through while shifting and a
    // copy is kept to hold the pins steady afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_r <= '0;
            r_hold_g <= '0;
            r_hold_b <= '0;
        end else if (r_clk_en) begin
            r_hold_r <= w_live_r;
            r_hold_g <= w_live_g;
            r_hold_b <= w_live_b;
        end
    end

    assign o_data_r     = r_clk_en ? w_live_r : r_hold_r;
    assign o_data_g     = r_clk_en ? w_live_g : r_hold_g;
    assign o_data_b     = r_clk_en ? w_live_b : r_hold_b;
    assign o_rd_row     = r_row;
    assign o_rd_col     = r_rd_col;
    assign o_rd_en      = r_rd_en;
    assign o_clk_enable = r_clk_en;
    assign o_latch      = r_latch;
    assign o_blank      = r_blank;
    assign o_row_addr   = r_row_addr;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
module tb_hub75_bcm_scheduler;

  localparam int COLS       = 4;
  localparam int ROWS       = 2;
  localparam int BITS       = 2;
  localparam int BASE_TICKS = 2;
  localparam int PXW        = 3 * BITS;
  localparam int FRAME_CYC  = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [$clog2(ROWS)-1:0] o_rd_row;
  logic [$clog2(COLS)-1:0] o_rd_col;
  logic                    o_rd_en;
  logic [PXW-1:0]          pix_top = '0;
  logic [PXW-1:0]          pix_bot = '0;
  logic [1:0]              o_data_r, o_data_g, o_data_b;
  logic                    o_clk_enable, o_latch, o_blank, o_busy, o_frame_done;
  logic [$clog2(ROWS)-1:0] o_row_addr;

  hub75_bcm_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_TICKS(BASE_TICKS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .o_rd_row(o_rd_row), .o_rd_col(o_rd_col), .o_rd_en(o_rd_en),
    .i_pix_top(pix_top), .i_pix_bot(pix_bot),
    .o_data_r(o_data_r), .o_data_g(o_data_g), .o_data_b(o_data_b),
    .o_clk_enable(o_clk_enable), .o_latch(o_latch), .o_blank(o_blank),
    .o_row_addr(o_row_addr), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  // ---------------- framebuffer model (1-cycle read latency) ----------------
  logic [PXW-1:0] fb_top [ROWS][COLS];
  logic [PXW-1:0] fb_bot [ROWS][COLS];

  always @(posedge clk) begin
    if (o_rd_en) begin
      pix_top <= fb_top[o_rd_row][o_rd_col];
      pix_bot <= fb_bot[o_rd_row][o_rd_col];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {bot,top} pairs for r, g, b of the given plane
  function automatic logic [5:0] exp_bits(input logic [PXW-1:0] top,
                                          input logic [PXW-1:0] bot,
                                          input int p);
    return {bot[2*BITS+p], top[2*BITS+p], bot[BITS+p], top[BITS+p], bot[p], top[p]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  int rd_cnt, ce_run, blank_run, dsp_cnt, latch_cnt;
  int m_slot, m_col, m_row, m_pl;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; ce_run = 0; blank_run = 0; dsp_cnt = 0; latch_cnt = 0;
      exp_q.delete();
    end else begin
      if (o_rd_en) begin
        m_slot = rd_cnt / COLS;
        m_col  = rd_cnt % COLS;
        m_row  = (m_slot / BITS) % ROWS;
        m_pl   = m_slot % BITS;
        check("rd_row", 32'(o_rd_row), m_row);
        check("rd_col", 32'(o_rd_col), m_col);
        check("blank_in_shift", 32'(o_blank), 1);
        exp_q.push_back(exp_bits(fb_top[m_row][m_col], fb_bot[m_row][m_col], m_pl));
        rd_cnt++;
      end
      if (o_clk_enable) begin
        ce_run++;
        check("blank_in_ce", 32'(o_blank), 1);
        if (exp_q.size() == 0) begin
          check("data_q_empty", 32'(exp_q.size()), 1);
        end else begin
          exp_v = exp_q.pop_front();
          check("pixel_data", 32'({o_data_r, o_data_g, o_data_b}), 32'(exp_v));
        end
      end else if (ce_run != 0) begin
        check("ce_len", ce_run, COLS);
        ce_run = 0;
      end
      if (!o_blank) begin
        blank_run++;
      end else if (blank_run != 0) begin
        check("disp_len", blank_run, BASE_TICKS << (dsp_cnt % BITS));
        dsp_cnt++;
        blank_run = 0;
      end
      if (o_latch) begin
        check("latch_row", 32'(o_row_addr), (latch_cnt / BITS) % ROWS);
        latch_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task wait_busy(input int budget, output int t);
    bit seen;
    seen = 0;
    t = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_busy) begin
        seen = 1;
        t = cyc;
      end
    end
    check("busy_seen", 32'(seen), 1);
  endtask

  task wait_done(input int budget, output int t);
    bit seen;
    seen = 0;
    t = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_frame_done) begin
        seen = 1;
        t = cyc;
      end
    end
    check("frame_done_seen", 32'(seen), 1);
  endtask

  task wait_row1_display(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!o_blank && o_row_addr == 1) seen = 1;
    end
    check("row1_display_seen", 32'(seen), 1);
  endtask

  task fill_fixed();
    // top r = 01, bottom r = 10, g/b zero
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        fb_top[r][c] = {2'b01, 4'b0000};
        fb_bot[r][c] = {2'b10, 4'b0000};
      end
  endtask

  task fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        fb_top[r][c] = PXW'($urandom_range(0, 63));
        fb_bot[r][c] = PXW'($urandom_range(0, 63));
      end
  endtask

  task check_reset_outputs(input string pfx);
    check({pfx, "_blank"}, 32'(o_blank), 1);
    check({pfx, "_latch"}, 32'(o_latch), 0);
    check({pfx, "_row_addr"}, 32'(o_row_addr), 0);
    check({pfx, "_busy"}, 32'(o_busy), 0);
    check({pfx, "_clk_en"}, 32'(o_clk_enable), 0);
    check({pfx, "_rd_en"}, 32'(o_rd_en), 0);
    check({pfx, "_frame_done"}, 32'(o_frame_done), 0);
  endtask

  // ---------------- stimulus ----------------
  int t0, t1, t2;

  initial begin
    fill_fixed();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_data", 32'({o_data_r, o_data_g, o_data_b}), 0);

    // Frame 1 (fixed pattern) and back-to-back frame 2
    rst_n = 1'b1;
    enable = 1'b1;
    wait_busy(20, t0);
    check("first_rd_en", 32'(o_rd_en), 1);
    wait_done(200, t1);
    check("frame_len", t1 - t0, FRAME_CYC);
    check("busy_at_done", 32'(o_busy), 1);
    @(negedge clk);
    check("done_pulse_width", 32'(o_frame_done), 0);
    check("busy_after_done", 32'(o_busy), 1);

    // Drop enable early in row 0: the frame still completes
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_done(200, t2);
    check("frame_len2", t2 - t1, FRAME_CYC);
    check("end_busy", 32'(o_busy), 0);
    check("end_blank", 32'(o_blank), 1);
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_rd_en", 32'(o_rd_en), 0);
    check("idle_done_low", 32'(o_frame_done), 0);

    // Random pixels, reset in the middle of a row-1 display
    fill_random();
    enable = 1'b1;
    wait_row1_display(200);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy(20, t0);
    wait_done(200, t1);
    check("frame_len3", t1 - t0, FRAME_CYC);
    enable = 1'b0;
    wait_done(200, t2);
    check("frame_len4", t2 - t1, FRAME_CYC);
    check("final_busy", 32'(o_busy), 0);
    repeat (2) @(negedge clk);
    check("q_drain", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
